ram32_arbiter: RTL and testbench
================================

// Module: ram32_arbiter
// PURPOSE
//  Two-requester arbiter sharing one ram32 instance (single port, 1-cycle read latency).
//  Port A is the barrel core (fetch + load/store); port B is the debug/loader port
//  (image download, memory inspection). Grants at most one access per cycle, either
//  round-robin or fixed-priority. Routes each read response back to the port that issued it.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width; word address is [ADDR_WIDTH-1:2], matches ram32
//  FIXED_PRIO  0   0 = round-robin; 1 = port A always wins a conflict
// PORTS
//  clk            in   1            clock; all state on rising edge
//  resetn         in   1            asynchronous, active-low reset
//  a_valid        in   1            port A request valid
//  a_ready        out  1            port A request accepted this cycle (combinational)
//  a_addr         in   ADDR_WIDTH-2 port A word address
//  a_wdata        in   32           port A write data
//  a_bwe          in   4            port A byte write enables; 4'b0000 = read
//  a_rvalid       out  1            port A read data valid (registered)
//  a_rdata        out  32           port A read data
//  b_valid/b_ready/b_addr/b_wdata/b_bwe/b_rvalid/b_rdata: same as port A, for port B
//  ram_addr       out  ADDR_WIDTH-2 to ram32 addr
//  ram_din        out  32           to ram32 din
//  ram_bwe        out  4            to ram32 bwe
//  ram_ren        out  1            to ram32 ren
//  ram_dout       in   32           from ram32 dout; valid 1 cycle after ren
// BEHAVIOUR
//  - Reset (resetn low, async): last_grant=B (so A wins the first conflict), rd_pend=0,
//    rd_owner=A. While resetn is low: a_ready=b_ready=0, ram_ren=0, ram_bwe=0,
//    a_rvalid=b_rvalid=0. rdata outputs are don't-care while rvalid is 0.
//  - Handshake: a request transfers in the cycle where valid && ready. The requester
//    holds valid, addr, wdata and bwe stable until ready. The arbiter never withdraws
//    ready from a request it granted in the same cycle.
//  - Grant, combinational: only one port valid -> grant that port. Both valid ->
//    FIXED_PRIO=1: grant A; FIXED_PRIO=0: grant the port that is not last_grant.
//    Neither valid -> no grant, ram_ren=0, ram_bwe=0, ram_addr/ram_din don't-care.
//  - Grant drives ram_addr/ram_din/ram_bwe from the winner. ram_ren=1 iff the winner's
//    bwe==0. Partial bwe is passed through unchanged: byte/half-word lanes are placed by
//    the requester.
//  - last_grant updates only on a transfer. Idle cycles leave it unchanged.
//  - Read return: on a read transfer in cycle N, set rd_pend=1 and rd_owner=winner at edge N.
//    Owner's rvalid=1 in cycle N+1 with rdata=ram_dout. The other port's rvalid=0.
//    rd_pend clears at edge N+1 unless a new read transfers in cycle N+1.
//    Back-to-back reads give one response per cycle, in order.
//  - Write: no response. Read-after-write to the same word in consecutive cycles
//    returns the new data, because the write commits at edge N before the read at N+1.
//  - Starvation bound (FIXED_PRIO=0): a continuously valid port is granted within 2 cycles.
//    FIXED_PRIO=1 gives port B no such bound (accepted: B is debug-only).
//  - Reset mid-operation: an in-flight read is dropped and no rvalid appears after
//    resetn rises. Requesters re-issue.
//  - rdata for a non-owner port is don't-care. Implementation mirrors ram_dout on both.
// STRUCTURE
//  - Shared package barrel_mem_pkg: PORT_A/PORT_B ids, BWE_READ=4'b0000,
//    BWE_WORD=4'b1111, ADDR_WIDTH default.
//  - Sub-module rr_arbiter2: req[1:0], FIXED_PRIO, last_grant in -> one-hot grant out.
//    Purely combinational; last_grant register lives in ram32_arbiter.
//  - Top: grant mux to ram32, rd_pend/rd_owner pipeline register, rvalid demux.
// TESTING (bench instantiates ram32_arbiter + ram32, zero-initialised image)
//  1. Reset: hold resetn=0 with a_valid=b_valid=1 -> ready=0, ram_bwe=0, ram_ren=0, no rvalid.
//  2. A writes 0xDEADBEEF @word 5 (bwe 1111), then reads @5 next cycle
//     -> a_rvalid one cycle after the read handshake, a_rdata=0xDEADBEEF, b_rvalid=0.
//  3. Both valid 6 cycles, FIXED_PRIO=0, reads @1 (A) and @2 (B)
//     -> grants alternate A,B,A,B,A,B; rvalid owner alternates one cycle behind.
//  4. Same stimulus, FIXED_PRIO=1 -> A granted all 6 cycles, b_ready=0 throughout.
//  5. B byte write 0x000000AA bwe 0001 @7 over 0x11223344 -> A reads @7 -> 0x112233AA.
//  6. A read granted, then resetn pulsed low for 1 cycle in N+1
//     -> no a_rvalid after release; first conflict afterwards goes to A.

Source files
------------

// File: rtl/barrel_mem_pkg.sv
// rtl/barrel_mem_pkg.sv - shared ids and constants for the barrel core memory path
// Contents:
//   port_t              requester id (PORT_A = barrel core, PORT_B = debug/loader)
//   BWE_READ, BWE_WORD  byte-write-enable encodings for a read and a full-word write
//   ADDR_WIDTH_DEFAULT  default byte-address width, matching ram32
package barrel_mem_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [3:0] BWE_READ = 4'b0000;
    localparam logic [3:0] BWE_WORD = 4'b1111;

    localparam int ADDR_WIDTH_DEFAULT = 12;

endpackage

// File: rtl/ram32.sv
// rtl/ram32.sv - single-port 32-bit word RAM with byte enables and 1-cycle read latency
// Ports:
//   clk   in   rising-edge clock
//   addr  in   word address [ADDR_WIDTH-3:0]
//   din   in   write data
//   bwe   in   byte write enables, bit i writes din[8i+7:8i]
//   ren   in   read enable; dout is valid in the following cycle
//   dout  out  registered read data
module ram32
    import barrel_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-3:0] addr,
    input  logic [31:0]           din,
    input  logic [3:0]            bwe,
    input  logic                  ren,
    output logic [31:0]           dout
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bwe[i]) begin
                mem[addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
        if (ren) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way combinational arbiter, round-robin or fixed priority
// Ports:
//   req         in   request vector, bit 0 = port A, bit 1 = port B
//   last_grant  in   port granted on the most recent transfer (register held by the caller)
//   grant       out  one-hot grant, same bit order as req; zero when nothing is requested
module rr_arbiter2
    import barrel_mem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                // On a conflict the port that did not win last time goes next,
                // unless port A is configured to always win.
                if (FIXED_PRIO || (last_grant == PORT_B)) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram32_arbiter.sv
// rtl/ram32_arbiter.sv - shares one ram32 between the barrel core (A) and debug port (B)
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   a_valid/a_ready                   port A request handshake (ready is combinational)
//   a_addr/a_wdata/a_bwe              port A word address, write data, byte enables (0 = read)
//   a_rvalid/a_rdata                  port A read response, one cycle after the read transfer
//   b_*                               same set for port B
//   ram_addr/ram_din/ram_bwe/ram_ren  request to ram32
//   ram_dout                          ram32 read data, valid one cycle after ram_ren
module ram32_arbiter
    import barrel_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-3:0] a_addr,
    input  logic [31:0]           a_wdata,
    input  logic [3:0]            a_bwe,
    output logic                  a_rvalid,
    output logic [31:0]           a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-3:0] b_addr,
    input  logic [31:0]           b_wdata,
    input  logic [3:0]            b_bwe,
    output logic                  b_rvalid,
    output logic [31:0]           b_rdata,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_bwe,
    output logic                  ram_ren,
    input  logic [31:0]           ram_dout
);

    port_t       last_grant;
    port_t       rd_owner;
    logic        rd_pend;
    logic [1:0]  grant_raw;
    logic [1:0]  grant;
    port_t       winner;
    logic        xfer;
    logic        rd_xfer;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant),
        .grant      (grant_raw)
    );

    // Ready is withheld for the whole time resetn is low, including the
    // asynchronous part of the cycle before the next clock edge.
    assign grant   = grant_raw & {2{resetn}};
    assign a_ready = grant[0];
    assign b_ready = grant[1];
    assign xfer    = |grant;

    always_comb begin
        winner   = PORT_A;
        ram_addr = a_addr;
        ram_din  = a_wdata;
        ram_bwe  = BWE_READ;
        ram_ren  = 1'b0;
        rd_xfer  = 1'b0;
        if (grant[1]) begin
            winner   = PORT_B;
            ram_addr = b_addr;
            ram_din  = b_wdata;
            ram_bwe  = b_bwe;
            ram_ren  = (b_bwe == BWE_READ);
            rd_xfer  = (b_bwe == BWE_READ);
        end else if (grant[0]) begin
            winner   = PORT_A;
            ram_addr = a_addr;
            ram_din  = a_wdata;
            ram_bwe  = a_bwe;
            ram_ren  = (a_bwe == BWE_READ);
            rd_xfer  = (a_bwe == BWE_READ);
        end
    end

    // rd_pend/rd_owner track the read issued last cycle so its data, which
    // ram32 presents one cycle later, is flagged to the right requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= PORT_B;
            rd_pend    <= 1'b0;
            rd_owner   <= PORT_A;
        end else begin
            if (xfer) begin
                last_grant <= winner;
            end
            rd_pend <= rd_xfer;
            if (rd_xfer) begin
                rd_owner <= winner;
            end
        end
    end

    assign a_rvalid = rd_pend && (rd_owner == PORT_A);
    assign b_rvalid = rd_pend && (rd_owner == PORT_B);
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram32_arbiter.sv
// tb/tb_ram32_arbiter.sv - directed self-checking bench for ram32_arbiter with ram32
module tb_ram32_arbiter;
    import barrel_mem_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic          a_valid, b_valid;
    logic [AW-3:0] a_addr, b_addr;
    logic [31:0]   a_wdata, b_wdata;
    logic [3:0]    a_bwe, b_bwe;

    logic          rr_a_ready, rr_b_ready, rr_a_rvalid, rr_b_rvalid;
    logic [31:0]   rr_a_rdata, rr_b_rdata;
    logic [AW-3:0] rr_ram_addr;
    logic [31:0]   rr_ram_din, rr_ram_dout;
    logic [3:0]    rr_ram_bwe;
    logic          rr_ram_ren;

    logic          fp_a_ready, fp_b_ready, fp_a_rvalid, fp_b_rvalid;
    logic [31:0]   fp_a_rdata, fp_b_rdata;
    logic [AW-3:0] fp_ram_addr;
    logic [31:0]   fp_ram_din, fp_ram_dout;
    logic [3:0]    fp_ram_bwe;
    logic          fp_ram_ren;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram32_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_ready(rr_a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_bwe(a_bwe), .a_rvalid(rr_a_rvalid), .a_rdata(rr_a_rdata),
        .b_valid(b_valid), .b_ready(rr_b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_bwe(b_bwe), .b_rvalid(rr_b_rvalid), .b_rdata(rr_b_rdata),
        .ram_addr(rr_ram_addr), .ram_din(rr_ram_din), .ram_bwe(rr_ram_bwe),
        .ram_ren(rr_ram_ren), .ram_dout(rr_ram_dout)
    );

    ram32 #(.ADDR_WIDTH(AW)) ram_rr (
        .clk(clk), .addr(rr_ram_addr), .din(rr_ram_din), .bwe(rr_ram_bwe),
        .ren(rr_ram_ren), .dout(rr_ram_dout)
    );

    ram32_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_bwe(a_bwe), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
        .b_valid(b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_bwe(b_bwe), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
        .ram_addr(fp_ram_addr), .ram_din(fp_ram_din), .ram_bwe(fp_ram_bwe),
        .ram_ren(fp_ram_ren), .ram_dout(fp_ram_dout)
    );

    ram32 #(.ADDR_WIDTH(AW)) ram_fp (
        .clk(clk), .addr(fp_ram_addr), .din(fp_ram_din), .bwe(fp_ram_bwe),
        .ren(fp_ram_ren), .dout(fp_ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [AW-3:0] ad, input logic [31:0] wd,
                           input logic [3:0] be);
        a_valid = v; a_addr = ad; a_wdata = wd; a_bwe = be;
    endtask

    task automatic drive_b(input logic v, input logic [AW-3:0] ad, input logic [31:0] wd,
                           input logic [3:0] be);
        b_valid = v; b_addr = ad; b_wdata = wd; b_bwe = be;
    endtask

    initial begin
        logic exp_a, prev_a;
        prev_a = 1'b0;

        // 1. reset held with both ports requesting
        resetn = 1'b0;
        drive_a(1'b1, 10'd3, 32'h0, BWE_READ);
        drive_b(1'b1, 10'd4, 32'h0, BWE_WORD);
        repeat (2) @(negedge clk);
        check("rst_rr_a_ready", rr_a_ready, 0);
        check("rst_rr_b_ready", rr_b_ready, 0);
        check("rst_rr_ram_bwe", rr_ram_bwe, 0);
        check("rst_rr_ram_ren", rr_ram_ren, 0);
        check("rst_rr_a_rvalid", rr_a_rvalid, 0);
        check("rst_rr_b_rvalid", rr_b_rvalid, 0);
        check("rst_fp_a_ready", fp_a_ready, 0);
        check("rst_fp_ram_ren", fp_ram_ren, 0);
        step();
        resetn = 1'b1;
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_b(1'b0, 10'd0, 32'h0, BWE_READ);

        // 2. A writes word 5 then reads it back
        step();
        drive_a(1'b1, 10'd5, 32'hDEADBEEF, BWE_WORD);
        @(negedge clk);
        check("t2_wr_a_ready", rr_a_ready, 1);
        check("t2_wr_ram_bwe", rr_ram_bwe, 4'hF);
        check("t2_wr_ram_ren", rr_ram_ren, 0);
        check("t2_wr_ram_addr", rr_ram_addr, 5);
        step();
        drive_a(1'b1, 10'd5, 32'h0, BWE_READ);
        @(negedge clk);
        check("t2_rd_a_ready", rr_a_ready, 1);
        check("t2_rd_ram_ren", rr_ram_ren, 1);
        check("t2_wr_no_rvalid", rr_a_rvalid, 0);
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        @(negedge clk);
        check("t2_a_rvalid", rr_a_rvalid, 1);
        check("t2_a_rdata", rr_a_rdata, 32'hDEADBEEF);
        check("t2_b_rvalid", rr_b_rvalid, 0);
        check("t2_fp_a_rdata", fp_a_rdata, 32'hDEADBEEF);

        // setup: A writes word 1, then B writes word 2 (leaves last_grant = B)
        step();
        drive_a(1'b1, 10'd1, 32'h11111111, BWE_WORD);
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_b(1'b1, 10'd2, 32'h22222222, BWE_WORD);
        @(negedge clk);
        check("setup_b_ready", rr_b_ready, 1);
        check("setup_no_rvalid", rr_a_rvalid, 0);

        // 3/4. both ports read for 6 cycles
        for (int i = 0; i < 6; i++) begin
            step();
            drive_a(1'b1, 10'd1, 32'h0, BWE_READ);
            drive_b(1'b1, 10'd2, 32'h0, BWE_READ);
            @(negedge clk);
            exp_a = ((i % 2) == 0);
            check($sformatf("t3_a_ready_%0d", i), rr_a_ready, exp_a);
            check($sformatf("t3_b_ready_%0d", i), rr_b_ready, !exp_a);
            check($sformatf("t4_a_ready_%0d", i), fp_a_ready, 1);
            check($sformatf("t4_b_ready_%0d", i), fp_b_ready, 0);
            if (i > 0) begin
                check($sformatf("t3_a_rvalid_%0d", i), rr_a_rvalid, prev_a);
                check($sformatf("t3_b_rvalid_%0d", i), rr_b_rvalid, !prev_a);
                check($sformatf("t3_rdata_%0d", i), rr_a_rdata,
                      prev_a ? 32'h11111111 : 32'h22222222);
                check($sformatf("t4_a_rvalid_%0d", i), fp_a_rvalid, 1);
                check($sformatf("t4_b_rvalid_%0d", i), fp_b_rvalid, 0);
                check($sformatf("t4_a_rdata_%0d", i), fp_a_rdata, 32'h11111111);
            end
            prev_a = exp_a;
        end
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_b(1'b0, 10'd0, 32'h0, BWE_READ);
        @(negedge clk);
        check("t3_last_b_rvalid", rr_b_rvalid, 1);
        check("t3_last_a_rvalid", rr_a_rvalid, 0);
        check("t3_last_rdata", rr_b_rdata, 32'h22222222);
        check("t4_last_a_rvalid", fp_a_rvalid, 1);
        check("t4_idle_ram_ren", rr_ram_ren, 0);
        step();
        @(negedge clk);
        check("t3_drain_a_rvalid", rr_a_rvalid, 0);
        check("t3_drain_b_rvalid", rr_b_rvalid, 0);

        // 5. B byte write over a full word, A reads it back
        step();
        drive_a(1'b1, 10'd7, 32'h11223344, BWE_WORD);
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_b(1'b1, 10'd7, 32'h000000AA, 4'b0001);
        @(negedge clk);
        check("t5_b_ready", rr_b_ready, 1);
        check("t5_ram_bwe", rr_ram_bwe, 4'b0001);
        step();
        drive_b(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_a(1'b1, 10'd7, 32'h0, BWE_READ);
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        @(negedge clk);
        check("t5_a_rvalid", rr_a_rvalid, 1);
        check("t5_a_rdata", rr_a_rdata, 32'h112233AA);
        check("t5_fp_a_rdata", fp_a_rdata, 32'h112233AA);

        // 6. read granted, then reset pulsed in the following cycle
        step();
        drive_a(1'b1, 10'd5, 32'h0, BWE_READ);
        @(negedge clk);
        check("t6_a_ready", rr_a_ready, 1);
        step();
        resetn = 1'b0;
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        @(negedge clk);
        check("t6_rst_a_rvalid", rr_a_rvalid, 0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("t6_post_a_rvalid", rr_a_rvalid, 0);
        check("t6_post_b_rvalid", rr_b_rvalid, 0);
        step();
        drive_a(1'b1, 10'd1, 32'h0, BWE_READ);
        drive_b(1'b1, 10'd2, 32'h0, BWE_READ);
        @(negedge clk);
        check("t6_conf_a_ready", rr_a_ready, 1);
        check("t6_conf_b_ready", rr_b_ready, 0);
        check("t6_conf_a_rvalid", rr_a_rvalid, 0);
        step();
        @(negedge clk);
        check("t6_next_b_ready", rr_b_ready, 1);
        check("t6_next_a_rvalid", rr_a_rvalid, 1);
        check("t6_next_a_rdata", rr_a_rdata, 32'h11111111);
        step();
        drive_a(1'b0, 10'd0, 32'h0, BWE_READ);
        drive_b(1'b0, 10'd0, 32'h0, BWE_READ);
        @(negedge clk);
        check("t6_b_rvalid", rr_b_rvalid, 1);
        check("t6_b_rdata", rr_b_rdata, 32'h22222222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
